// File: rtl/iob_ram_2p_be_arb.sv
// Two-requester arbiter in front of a 2-port byte-enable RAM.
// The write and read ports are arbitrated independently, each with its own
// 1-bit round-robin pointer. Read data comes back one cycle after the grant
// and is steered to the requester that owns it with an rvalid pulse.
module iob_ram_2p_be_arb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  input  logic [ADDR_W-1:0]      a_addr,
  input  logic [DATA_W-1:0]      a_wdata,
  input  logic [DATA_W/8-1:0]    a_wstrb,
  output logic                   a_ready,
  output logic                   a_rvalid,
  output logic [DATA_W-1:0]      a_rdata,
  input  logic                   b_valid,
  input  logic [ADDR_W-1:0]      b_addr,
  input  logic [DATA_W-1:0]      b_wdata,
  input  logic [DATA_W/8-1:0]    b_wstrb,
  output logic                   b_ready,
  output logic                   b_rvalid,
  output logic [DATA_W-1:0]      b_rdata,
  output logic [DATA_W/8-1:0]    ram_w_en,
  output logic [ADDR_W-1:0]      ram_w_addr,
  output logic [DATA_W-1:0]      ram_w_data,
  output logic                   ram_r_en,
  output logic [ADDR_W-1:0]      ram_r_addr,
  input  logic [DATA_W-1:0]      ram_r_data
);

  localparam int STRB_W = DATA_W / 8;

  // Index 0 is requester A, index 1 is requester B.
  logic [1:0]        req_v;
  logic [STRB_W-1:0] req_strb [2];
  logic [1:0]        wr_req;
  logic [1:0]        rd_req;
  logic [1:0]        w_gnt;
  logic [1:0]        r_gnt;
  logic [1:0]        rvalid_vec;

  logic w_prio_reg, w_prio_next;
  logic r_prio_reg, r_prio_next;
  logic rd_owner_vld_reg, rd_owner_vld_next;
  logic rd_owner_reg, rd_owner_next;

  assign req_v       = {b_valid, a_valid};
  assign req_strb[0] = a_wstrb;
  assign req_strb[1] = b_wstrb;

  // A request with any byte enabled is a write; an all-zero strobe is a read.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign wr_req[gi]     = req_v[gi] & (|req_strb[gi]);
      assign rd_req[gi]     = req_v[gi] & ~(|req_strb[gi]);
      assign rvalid_vec[gi] = rd_owner_vld_reg & (rd_owner_reg == 1'(gi));
    end
  endgenerate

  // Grants: a lone requester always wins; on contention the pointer decides.
  // Everything is held off while reset is asserted.
  assign w_gnt[0] = ~rst & wr_req[0] & (~wr_req[1] | ~w_prio_reg);
  assign w_gnt[1] = ~rst & wr_req[1] & (~wr_req[0] |  w_prio_reg);
  assign r_gnt[0] = ~rst & rd_req[0] & (~rd_req[1] | ~r_prio_reg);
  assign r_gnt[1] = ~rst & rd_req[1] & (~rd_req[0] |  r_prio_reg);

  assign a_ready = w_gnt[0] | r_gnt[0];
  assign b_ready = w_gnt[1] | r_gnt[1];

  // On a contested cycle the winner was the prioritised side, so handing
  // priority to the loser is simply a toggle.
  assign w_prio_next       = (wr_req[0] & wr_req[1]) ? ~w_prio_reg : w_prio_reg;
  assign r_prio_next       = (rd_req[0] & rd_req[1]) ? ~r_prio_reg : r_prio_reg;
  assign rd_owner_vld_next = |r_gnt;
  assign rd_owner_next     = r_gnt[1];

  // Drive the RAM ports from whichever requester won each port.
  always_comb begin
    ram_w_en   = '0;
    ram_w_addr = a_addr;
    ram_w_data = a_wdata;
    ram_r_en   = 1'b0;
    ram_r_addr = a_addr;
    if (w_gnt[1]) begin
      ram_w_en   = b_wstrb;
      ram_w_addr = b_addr;
      ram_w_data = b_wdata;
    end else if (w_gnt[0]) begin
      ram_w_en   = a_wstrb;
    end
    if (r_gnt[1]) begin
      ram_r_en   = 1'b1;
      ram_r_addr = b_addr;
    end else if (r_gnt[0]) begin
      ram_r_en   = 1'b1;
    end
  end

  // Priority pointers and read-return ownership; clearing the owner on reset
  // kills any read that was in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_prio_reg       <= 1'b0;
      r_prio_reg       <= 1'b0;
      rd_owner_vld_reg <= 1'b0;
      rd_owner_reg     <= 1'b0;
    end else begin
      w_prio_reg       <= w_prio_next;
      r_prio_reg       <= r_prio_next;
      rd_owner_vld_reg <= rd_owner_vld_next;
      rd_owner_reg     <= rd_owner_next;
    end
  end

  assign a_rvalid = rvalid_vec[0];
  assign b_rvalid = rvalid_vec[1];
  assign a_rdata  = ram_r_data;
  assign b_rdata  = ram_r_data;

endmodule

// File: tb/tb_iob_ram_2p_be_arb.sv
// Directed bench for iob_ram_2p_be_arb with a behavioural 2-port RAM.
// Handshake/RAM-port checks happen in the driver; read returns are checked
// by a monitor against a queue of expected {owner, data} entries.
module tb_iob_ram_2p_be_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [9:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic [3:0]  a_wstrb, b_wstrb;
  logic        a_ready, b_ready, a_rvalid, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic [3:0]  ram_w_en;
  logic [9:0]  ram_w_addr, ram_r_addr;
  logic [31:0] ram_w_data, ram_r_data;
  logic        ram_r_en;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q [$];
  logic [31:0] mem [1024];

  iob_ram_2p_be_arb #(.DATA_W(32), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_wdata(a_wdata), .a_wstrb(a_wstrb),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_addr(b_addr), .b_wdata(b_wdata), .b_wstrb(b_wstrb),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: byte writes, registered read returning old data.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    ram_r_data = 32'h0;
  end
  always @(posedge clk) begin
    if (ram_r_en) ram_r_data <= mem[ram_r_addr];
    for (int k = 0; k < 4; k++)
      if (ram_w_en[k]) mem[ram_w_addr][k*8 +: 8] <= ram_w_data[k*8 +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid must match the oldest expected read return.
  always @(negedge clk) begin
    if (a_rvalid || b_rvalid) begin
      logic [32:0] e;
      if (a_rvalid && b_rvalid) begin
        checks++; errors++;
        $display("FAIL rvalid_both: got a=1 b=1 expected one-hot");
      end else if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rvalid_unexpected: got a=%0b b=%0b expected none", a_rvalid, b_rvalid);
      end else begin
        e = exp_q.pop_front();
        chk("rd_owner", {31'h0, b_rvalid}, {31'h0, e[32]});
        chk("rd_data", b_rvalid ? b_rdata : a_rdata, e[31:0]);
        $display("read return owner=%s data=%h", b_rvalid ? "B" : "A", b_rvalid ? b_rdata : a_rdata);
      end
    end
  end

  task automatic idle();
    a_valid = 0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
    b_valid = 0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
  endtask

  // One request cycle: drive, check handshake and RAM ports mid-cycle,
  // optionally queue the expected read return, then advance one edge.
  task automatic step(input string name,
                      input logic av, input logic [9:0] aad, input logic [31:0] awd, input logic [3:0] ast,
                      input logic bv, input logic [9:0] bad, input logic [31:0] bwd, input logic [3:0] bst,
                      input logic ear, input logic ebr, input logic [3:0] ewen, input logic eren,
                      input logic push, input logic pown, input logic [31:0] pdata);
    a_valid = av; a_addr = aad; a_wdata = awd; a_wstrb = ast;
    b_valid = bv; b_addr = bad; b_wdata = bwd; b_wstrb = bst;
    @(negedge clk);
    chk({name, ".a_ready"}, {31'h0, a_ready}, {31'h0, ear});
    chk({name, ".b_ready"}, {31'h0, b_ready}, {31'h0, ebr});
    chk({name, ".ram_w_en"}, {28'h0, ram_w_en}, {28'h0, ewen});
    chk({name, ".ram_r_en"}, {31'h0, ram_r_en}, {31'h0, eren});
    $display("%s: a_ready=%0b b_ready=%0b w_en=%h r_en=%0b", name, a_ready, b_ready, ram_w_en, ram_r_en);
    if (push) exp_q.push_back({pown, pdata});
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    // Requests presented during reset must be ignored.
    a_valid = 1; a_addr = 10'h010; a_wdata = 32'hFFFF_FFFF; a_wstrb = 4'hF;
    @(negedge clk);
    chk("reset.a_ready", {31'h0, a_ready}, 32'h0);
    chk("reset.ram_w_en", {28'h0, ram_w_en}, 32'h0);
    chk("reset.rvalid", {30'h0, b_rvalid, a_rvalid}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    idle();
    rst = 1'b0;

    // Basic write then read.
    step("wr_a_010", 1, 10'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 1, 0, 4'hF, 0, 0, 0, 0);
    step("rd_a_010", 1, 10'h010, 0, 4'h0, 0, 0, 0, 0, 1, 0, 4'h0, 1, 1, 0, 32'hDEADBEEF);

    // Byte enables merge into the existing word.
    step("wr_a_020", 1, 10'h020, 32'h11223344, 4'hF, 0, 0, 0, 0, 1, 0, 4'hF, 0, 0, 0, 0);
    step("wr_b_020", 0, 0, 0, 0, 1, 10'h020, 32'hAABBCCDD, 4'h5, 0, 1, 4'h5, 0, 0, 0, 0);
    step("rd_a_020", 1, 10'h020, 0, 4'h0, 0, 0, 0, 0, 1, 0, 4'h0, 1, 1, 0, 32'h11BB33DD);

    // Contested writes alternate A,B,A,B,A (leaves w_prio pointing at B).
    step("cw1", 1, 10'h060, 32'h1, 4'hF, 1, 10'h070, 32'h2, 4'h3, 1, 0, 4'hF, 0, 0, 0, 0);
    step("cw2", 1, 10'h060, 32'h1, 4'hF, 1, 10'h070, 32'h2, 4'h3, 0, 1, 4'h3, 0, 0, 0, 0);
    step("cw3", 1, 10'h060, 32'h1, 4'hF, 1, 10'h070, 32'h2, 4'h3, 1, 0, 4'hF, 0, 0, 0, 0);
    step("cw4", 1, 10'h060, 32'h1, 4'hF, 1, 10'h070, 32'h2, 4'h3, 0, 1, 4'h3, 0, 0, 0, 0);
    step("cw5", 1, 10'h060, 32'h1, 4'hF, 1, 10'h070, 32'h2, 4'h3, 1, 0, 4'hF, 0, 0, 0, 0);

    // Concurrent write and read on separate ports.
    step("wr_b_040", 0, 0, 0, 0, 1, 10'h040, 32'h0BADC0DE, 4'hF, 0, 1, 4'hF, 0, 0, 0, 0);
    step("conc", 1, 10'h030, 32'hCAFEF00D, 4'hF, 1, 10'h040, 0, 4'h0, 1, 1, 4'hF, 1, 1, 1, 32'h0BADC0DE);
    step("rd_b_030", 0, 0, 0, 0, 1, 10'h030, 0, 4'h0, 0, 1, 4'h0, 1, 1, 1, 32'hCAFEF00D);

    // Same-address write/read returns the old data.
    step("hazard", 1, 10'h050, 32'h12345678, 4'hF, 1, 10'h050, 0, 4'h0, 1, 1, 4'hF, 1, 1, 1, 32'h0);
    step("rd_a_050", 1, 10'h050, 0, 4'h0, 0, 0, 0, 0, 1, 0, 4'h0, 1, 1, 0, 32'h12345678);

    // Contested back-to-back reads A,B,A (leaves r_prio pointing at B).
    step("cr1", 1, 10'h010, 0, 4'h0, 1, 10'h020, 0, 4'h0, 1, 0, 4'h0, 1, 1, 0, 32'hDEADBEEF);
    step("cr2", 1, 10'h010, 0, 4'h0, 1, 10'h020, 0, 4'h0, 0, 1, 4'h0, 1, 1, 1, 32'h11BB33DD);
    step("cr3", 1, 10'h010, 0, 4'h0, 1, 10'h020, 0, 4'h0, 1, 0, 4'h0, 1, 1, 0, 32'hDEADBEEF);

    // Read granted, then async reset between edges kills the return.
    step("rd_pre_rst", 1, 10'h010, 0, 4'h0, 0, 0, 0, 0, 1, 0, 4'h0, 1, 0, 0, 0);
    #1 rst = 1'b1;
    a_valid = 1; a_addr = 10'h010; a_wdata = 32'hFFFF_FFFF; a_wstrb = 4'hF;
    #1;
    chk("async_rst.rvalid", {30'h0, b_rvalid, a_rvalid}, 32'h0);
    chk("async_rst.ram_w_en", {28'h0, ram_w_en}, 32'h0);
    chk("async_rst.a_ready", {31'h0, a_ready}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    idle();
    rst = 1'b0;

    // Pointers are back at A after reset; memory untouched by reset-time write.
    step("post_cw", 1, 10'h060, 32'h1, 4'hF, 1, 10'h070, 32'h2, 4'h3, 1, 0, 4'hF, 0, 0, 0, 0);
    step("post_cr", 1, 10'h010, 0, 4'h0, 1, 10'h020, 0, 4'h0, 1, 0, 4'h0, 1, 1, 0, 32'hDEADBEEF);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_ram_2p_be_arb.md
Name: iob_ram_2p_be_arb

Overview:
Two-requester arbiter that shares one 2-port byte-enable RAM (separate write and read ports, 1-cycle registered read) between requesters A and B.
- Each requester issues single-beat valid/ready requests. Non-zero wstrb means write; zero wstrb means read.
- Writes and reads are arbitrated independently, each port with its own round-robin pointer, so one write and one read can be granted per cycle.
- Read data returns to the owning requester with an rvalid pulse. Sits between CPU/DMA-style masters and the RAM instance.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8
ADDR_W, 10, word address width
STRB_W, DATA_W/8, derived (localparam); byte-enable width

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous active-high reset
a_valid  input  1  requester A request valid
a_addr  input  ADDR_W  requester A word address
a_wdata  input  DATA_W  requester A write data
a_wstrb  input  STRB_W  requester A byte enables; 0 = read
a_ready  output  1  request A accepted this cycle
a_rvalid  output  1  A read data valid pulse
a_rdata  output  DATA_W  A read data
b_valid, b_addr, b_wdata, b_wstrb, b_ready, b_rvalid, b_rdata: same as A, for requester B
ram_w_en  output  STRB_W  RAM byte write enables
ram_w_addr  output  ADDR_W  RAM write address
ram_w_data  output  DATA_W  RAM write data
ram_r_en  output  1  RAM read enable
ram_r_addr  output  ADDR_W  RAM read address
ram_r_data  input  DATA_W  RAM read data, valid 1 cycle after ram_r_en

Behaviour:
- Classification: wr_x = x_valid & |x_wstrb; rd_x = x_valid & ~|x_wstrb.
- Write port arbitration (combinational):
  - Exactly one of wr_a/wr_b: that requester is granted.
  - Both: the requester named by w_prio is granted.
  - Grant drives ram_w_en = winner wstrb, ram_w_addr, ram_w_data from the winner; otherwise ram_w_en = 0.
- Read port arbitration: identical rules using rd_a/rd_b and r_prio. Grant drives ram_r_en = 1 and ram_r_addr from the winner.
- x_ready = write grant to x OR read grant to x. Combinational from valid inputs; no request buffering.
- A requester holding valid with ready low keeps its request; the block never drops or reorders requests.
- Round-robin pointers w_prio and r_prio:
  - Each is a 1-bit register; 0 = A has priority, 1 = B has priority. Reset to 0.
  - Updated only on a contested cycle (both requesting that port): the pointer flips to the loser.
  - Uncontested grants leave the pointer unchanged.
  - Both pointers update in the same cycle when both ports are contested.
- Read return:
  - Register rd_owner_vld/rd_owner on each read grant.
  - Next cycle: x_rvalid = rd_owner_vld & (rd_owner == x), and x_rdata = ram_r_data for both requesters.
  - rvalid is a single-cycle pulse per granted read. Back-to-back reads produce back-to-back rvalid pulses in grant order.
- Simultaneous write and read to the same address in one cycle: the read returns the pre-write (old) data. No forwarding.
- Reset values:
  - rvalid outputs 0; w_prio = r_prio = 0; rd_owner_vld = 0.
  - While rst is high: a_ready, b_ready, ram_w_en and ram_r_en are forced 0.
- Reset mid-operation: a read granted in the cycle before rst asserts produces no rvalid. No RAM write occurs during reset.
- Latency:
  - Write: accepted and committed on the same edge (0 extra cycles).
  - Read: data on x_rdata with x_rvalid exactly 1 cycle after x_ready.

Test Plan:
- A write only (addr 0x010, wdata 0xDEADBEEF, wstrb 0xF); then A read of 0x010 -> a_ready=1 both cycles; a_rvalid=1 one cycle after read accept with a_rdata=0xDEADBEEF; b_rvalid stays 0.
- Byte enables: A writes 0x11223344 (wstrb 0xF) to 0x020, then B writes 0xAABBCCDD with wstrb 0x5 to 0x020; read 0x020 -> 0x11BB33DD.
- Contested writes: A and B both hold write valid 4 cycles after reset -> grants A,B,A,B; w_prio toggles each cycle; the non-granted requester sees ready=0.
- Concurrent ports: A writes 0x030 while B reads 0x040 in the same cycle -> both ready=1, ram_w_en=0xF and ram_r_en=1 together; b_rvalid next cycle with 0x040 contents.
- Same-address hazard: 0x050 holds 0x0; A writes 0x12345678 to 0x050 while B reads 0x050 -> b_rdata=0x00000000; a subsequent read returns 0x12345678.
- Async reset: assert rst between clock edges the cycle after a read grant -> a_rvalid/b_rvalid=0 immediately, no rvalid pulse after release, w_prio=r_prio=0 (first contested grant after reset goes to A).
